// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// Supports per-master lock with a bounded hold window; routes read data back.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rd,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rd,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wd,
    input  logic [DATA_W-1:0] ram_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              resp_pend_q, resp_pend_d;
    logic              resp_id_q, resp_id_d;

    logic   gnt0, gnt1;
    logic   cur_id, cur_req, cur_lock, oth_req;
    state_t oth_state;

    // Beat qualification and RAM port mux; reset blocks any beat
    always_comb begin
        gnt0     = (state_q == OWN0) & m0_req & ~reset;
        gnt1     = (state_q == OWN1) & m1_req & ~reset;
        ram_we   = (gnt0 & m0_we) | (gnt1 & m1_we);
        ram_addr = '0;
        ram_wd   = '0;
        if (gnt0) begin
            ram_addr = m0_addr;
            ram_wd   = m0_wd;
        end else if (gnt1) begin
            ram_addr = m1_addr;
            ram_wd   = m1_wd;
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // Read data goes to whichever master issued the read last cycle
    always_comb begin
        m0_rvalid = resp_pend_q & ~resp_id_q & ~reset;
        m1_rvalid = resp_pend_q & resp_id_q & ~reset;
        m0_rd     = m0_rvalid ? ram_rd : '0;
        m1_rd     = m1_rvalid ? ram_rd : '0;
    end

    // Ownership, hold window and response tracking next-state
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        resp_pend_d = (gnt0 & ~m0_we) | (gnt1 & ~m1_we);
        resp_id_d   = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : resp_id_q);
        cur_id      = (state_q == OWN1);
        cur_req     = cur_id ? m1_req : m0_req;
        cur_lock    = cur_id ? m1_lock : m0_lock;
        oth_req     = cur_id ? m0_req : m1_req;
        oth_state   = cur_id ? OWN0 : OWN1;
        unique case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_d = OWN0;
                end else if (m1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!cur_req) begin
                    state_d    = oth_req ? oth_state : IDLE;
                    last_d     = cur_id;
                    hold_cnt_d = '0;
                end else if (oth_req) begin
                    if (cur_lock && hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end else begin
                        state_d    = oth_state;
                        last_d     = cur_id;
                        hold_cnt_d = '0;
                    end
                end else begin
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // State registers; reset drops ownership and any pending response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            hold_cnt_q  <= '0;
            resp_pend_q <= 1'b0;
            resp_id_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            resp_pend_q <= resp_pend_d;
            resp_id_q   <= resp_id_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single-port synchronous RAM between the ktc32 core (m0) and a secondary master (m1), such as a boot loader or DMA engine.
- Sits between the masters and the ram instance at board top level.
- Round-robin arbitration with optional per-master lock and a bounded hold window.
- Routes 1-cycle-latency read data back to the master that issued the read.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_HOLD, 8, max consecutive beats one locked owner may take while the other master waits (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
m0_req  in  1  master 0 beat request
m0_we  in  1  master 0 write enable (1=write, 0=read)
m0_lock  in  1  master 0 requests to keep ownership
m0_addr  in  ADDR_W  master 0 address
m0_wd  in  DATA_W  master 0 write data
m0_gnt  out  1  master 0 beat accepted this cycle
m0_rvalid  out  1  master 0 read data valid
m0_rd  out  DATA_W  master 0 read data
m1_req, m1_we, m1_lock, m1_addr, m1_wd, m1_gnt, m1_rvalid, m1_rd: same as m0, for master 1
ram_we  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address
ram_wd  out  DATA_W  RAM write data
ram_rd  in  DATA_W  RAM read data, valid 1 cycle after address

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- States: IDLE, OWN0, OWN1.
  - Registers: state, last (last served master), hold_cnt, resp_pend, resp_id.
- Reset values:
  - state=IDLE, last=1 (so m0 wins the first tie), hold_cnt=0, resp_pend=0.
  - All gnt and rvalid outputs are 0.
  - ram_we=0, ram_addr=0, ram_wd=0.
- Grant:
  - mX_gnt = (state==OWNx) & mX_req. A beat transfers in the cycle where gnt is high.
  - The non-owner's gnt is always 0.
  - A master keeps its req, we, addr and wd stable until it sees gnt.
- RAM drive:
  - During a beat, ram_addr/ram_wd come from the owner and ram_we = owner_we.
  - With no beat, ram_we=0 and addr/wd are held at 0.
  - A write is never issued without a grant.
- IDLE:
  - Only m0_req or only m1_req: go to OWN0 or OWN1 next cycle. This gives 1 cycle of arbitration latency from idle.
  - Both requesting: grant the master != last.
  - Neither requesting: stay in IDLE.
- OWNx, evaluated every cycle. Let other = the other master's req.
  - Beat taken, lock_x=1, other=0: stay. hold_cnt stays 0.
  - Beat taken, lock_x=1, other=1, hold_cnt < MAX_HOLD-1: stay, hold_cnt++.
  - Beat taken, lock_x=1, other=1, hold_cnt == MAX_HOLD-1: forced switch to the other owner next cycle. hold_cnt=0.
  - Beat taken, lock_x=0, other=1: switch directly to the other owner. No IDLE bubble.
  - Beat taken, lock_x=0, other=0: stay if mX_req stays high next cycle, else go to IDLE.
  - No beat (req_x low): go to OWN(other) if other=1, else IDLE.
  - On any switch: last=x, hold_cnt=0.
- Read return:
  - A read beat in cycle N sets resp_pend=1 and resp_id=owner at the N+1 edge.
  - In cycle N+1, m{resp_id}_rvalid=1 and m{resp_id}_rd=ram_rd.
  - Back-to-back reads give rvalid on consecutive cycles.
  - A write beat sets resp_pend=0.
  - The non-addressed master's rd=0 and rvalid=0.
- Simultaneous events:
  - An ownership switch in the same cycle as a pending response still routes the response to the original issuer, via resp_id.
- Reset mid-operation:
  - Any pending response is dropped (rvalid stays 0 after reset).
  - Ownership is released and state returns to IDLE.
  - No RAM write is issued in the reset cycle.
- Masters must not change addr/we while gnt=0 and req=1. Behaviour otherwise is undefined but safe: no write occurs without gnt.

Test Plan:
1. m0 read at 0x10 from idle (RAM[0x10]=0xDEADBEEF):
   - m0_gnt=1 at cycle 1.
   - m0_rvalid=1, m0_rd=0xDEADBEEF at cycle 2.
   - m1_rvalid stays 0.
2. m0 and m1 request together from reset, both unlocked, continuous req:
   - Grants alternate m0,m1,m0,m1.
   - No idle cycle between them after the first grant.
3. m1 locked, writing 0x1..0xC to 0x100..0x12C, with m0 requesting throughout (MAX_HOLD=4):
   - m1 gets 4 beats, then m0 gets one beat, then m1 resumes.
   - RAM holds all 12 words.
4. m1 write 0x0000000F to 0x54 interleaved with m0 read of 0x54:
   - ram_we pulses once.
   - m0 reads 0x0000000F.
   - m1 gets no rvalid.
5. Reset asserted the cycle after an m0 read beat:
   - m0_rvalid stays 0.
   - state goes to IDLE; ram_we=0.
   - The next m1_req is granted 1 cycle after reset deasserts.
6. m0 read beat on the same cycle m1 takes ownership:
   - m0_rvalid with the correct data arrives next cycle.
   - m1_gnt is also high that cycle.
